// File: rtl/dcache_load_pipe.sv
// Dcache-side responder of the three-stage load protocol, one instance per load port.
// s0 launches tag/TLB reads, s1 resolves hit/miss/conflict, s2 returns line data or an exception.
module dcache_load_pipe #(
    parameter int WAYS       = 4,
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 64,
    parameter int TAGW       = 27,
    parameter int VAW        = 39,
    parameter int LQW        = 4,
    localparam int IDXW      = $clog2(SETS),
    localparam int WAYW      = $clog2(WAYS),
    localparam int OFFW      = $clog2(LINE_BYTES),
    localparam int PAW       = TAGW + IDXW + OFFW,
    localparam int LINEW     = LINE_BYTES * 8
) (
    input  logic                     clk,
    input  logic                     rst,
    // load unit side
    input  logic                     s0_req_i,
    input  logic [VAW-1:0]           s0_vaddr_i,
    input  logic [LQW-1:0]           s0_lqidx_i,
    output logic                     s0_gnt_o,
    input  logic                     s1_req_i,
    output logic                     s1_rdy_o,
    output logic                     s1_conflict_o,
    output logic                     s1_tlbhit_o,
    output logic                     s1_cachehit_o,
    output logic [PAW-1:0]           s1_paddr_o,
    input  logic                     s2_req_i,
    output logic                     s2_rdy_o,
    output logic                     s2_has_except_o,
    output logic [3:0]               s2_except_o,
    output logic                     s2_data_vld_o,
    output logic [LINEW-1:0]         s2_data_o,
    output logic [LQW-1:0]           s2_lqidx_o,
    // tag / data arrays
    output logic                     tag_rd_en_o,
    output logic [IDXW-1:0]          tag_rd_set_o,
    input  logic [WAYS*(TAGW+1)-1:0] tag_rd_data_i,
    output logic                     data_rd_en_o,
    output logic [IDXW-1:0]          data_rd_set_o,
    output logic [WAYW-1:0]          data_rd_way_o,
    input  logic [LINEW-1:0]         data_rd_data_i,
    input  logic                     bank_busy_i,
    // DTLB
    output logic                     tlb_req_o,
    output logic [VAW-1:0]           tlb_vaddr_o,
    input  logic                     tlb_resp_vld_i,
    input  logic [PAW-1:0]           tlb_paddr_i,
    input  logic                     tlb_pf_i,
    input  logic                     tlb_af_i,
    // miss unit
    output logic                     miss_req_o,
    output logic [PAW-1:0]           miss_paddr_o,
    input  logic                     miss_gnt_i
);
    localparam logic [3:0] EXC_LPF = 4'd13;
    localparam logic [3:0] EXC_LAF = 4'd5;

    logic            s1_v_q, s1_v_d;
    logic [IDXW-1:0] s1_idx_q, s1_idx_d;
    logic [LQW-1:0]  s1_lq_q, s1_lq_d;
    logic            s2_v_q, s2_v_d, s2_hit_q, s2_hit_d;
    logic            s2_pf_q, s2_pf_d, s2_af_q, s2_af_d;
    logic [LQW-1:0]  s2_lq_q, s2_lq_d;

    logic            s0_acc, s1_act, s2_resp, any_match, fault;
    logic [WAYS-1:0] way_match;
    logic [WAYW-1:0] hit_way;
    logic [TAGW-1:0] ptag;
    logic            unused_ok;

    // s0: accept and launch tag read + translation
    assign s0_gnt_o     = !rst && !bank_busy_i;
    assign s0_acc       = s0_req_i && s0_gnt_o;
    assign tag_rd_en_o  = s0_acc;
    assign tag_rd_set_o = s0_acc ? s0_vaddr_i[OFFW +: IDXW] : '0;
    assign tlb_req_o    = s0_acc;
    assign tlb_vaddr_o  = s0_acc ? s0_vaddr_i : '0;

    // s1: tag compare against the translated address
    assign s1_act = s1_v_q && !rst;
    assign ptag   = tlb_paddr_i[PAW-1 -: TAGW];

    for (genvar g = 0; g < WAYS; g++) begin : g_cmp
        assign way_match[g] = tag_rd_data_i[g*(TAGW+1)+TAGW] &&
                              (tag_rd_data_i[g*(TAGW+1) +: TAGW] == ptag);
    end

    // descending scan so the lowest matching way wins
    always_comb begin
        any_match = 1'b0;
        hit_way   = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (way_match[w]) begin
                any_match = 1'b1;
                hit_way   = WAYW'(w);
            end
        end
    end

    assign fault         = tlb_pf_i || tlb_af_i;
    assign s1_rdy_o      = s1_act;
    assign s1_tlbhit_o   = s1_act && tlb_resp_vld_i;
    assign s1_paddr_o    = s1_act ? tlb_paddr_i : '0;
    assign s1_cachehit_o = s1_tlbhit_o && any_match && !fault;
    assign s1_conflict_o = s1_act && bank_busy_i;

    assign data_rd_en_o  = s1_act && s1_req_i && s1_cachehit_o && !s1_conflict_o;
    assign data_rd_set_o = data_rd_en_o ? s1_idx_q : '0;
    assign data_rd_way_o = data_rd_en_o ? hit_way : '0;
    assign miss_req_o    = s1_act && s1_req_i && s1_tlbhit_o && !s1_cachehit_o &&
                           !fault && !s1_conflict_o;
    assign miss_paddr_o  = miss_req_o ? {tlb_paddr_i[PAW-1:OFFW], {OFFW{1'b0}}} : '0;
    // the load unit replays on its own, so the miss grant carries no state here
    assign unused_ok     = miss_gnt_i;

    always_comb begin
        s1_v_d   = s0_acc;
        s1_idx_d = s0_vaddr_i[OFFW +: IDXW];
        s1_lq_d  = s0_lqidx_i;
        s2_v_d   = s1_act && s1_req_i;
        s2_hit_d = data_rd_en_o;
        s2_pf_d  = s2_v_d && s1_tlbhit_o && tlb_pf_i;
        s2_af_d  = s2_v_d && s1_tlbhit_o && tlb_af_i;
        s2_lq_d  = s1_lq_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_idx_q <= '0;
            s1_lq_q  <= '0;
            s2_v_q   <= 1'b0;
            s2_hit_q <= 1'b0;
            s2_pf_q  <= 1'b0;
            s2_af_q  <= 1'b0;
            s2_lq_q  <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_idx_q <= s1_idx_d;
            s1_lq_q  <= s1_lq_d;
            s2_v_q   <= s2_v_d;
            s2_hit_q <= s2_hit_d;
            s2_pf_q  <= s2_pf_d;
            s2_af_q  <= s2_af_d;
            s2_lq_q  <= s2_lq_d;
        end
    end

    // s2: line arrives from the data array this cycle; pf outranks af
    assign s2_rdy_o        = s2_v_q && !rst;
    assign s2_resp         = s2_rdy_o && s2_req_i;
    assign s2_data_vld_o   = s2_resp && s2_hit_q;
    assign s2_data_o       = s2_data_vld_o ? data_rd_data_i : '0;
    assign s2_has_except_o = s2_resp && (s2_pf_q || s2_af_q);
    assign s2_except_o     = s2_has_except_o ? (s2_pf_q ? EXC_LPF : EXC_LAF) : 4'd0;
    assign s2_lqidx_o      = s2_rdy_o ? s2_lq_q : '0;
endmodule
